key_opcode_encoder: RTL and testbench
=====================================

KEY_OPCODE_ENCODER -- requirements
Module: key_opcode_encoder

Interface
REQ-001 SHALL have parameter DB_COUNT, default 20'd500000, the number of consecutive stable synchronized samples required to accept a button level change.
REQ-002 SHALL have parameter SW_W, default 8, the width of the number switch bus.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-005 btn_num  input  1  raw asynchronous "number entered" button, active-high.
REQ-006 btn_enter  input  1  raw "enter" button, active-high.
REQ-007 btn_add, btn_sub, btn_mul, btn_div  input  1 each  raw operator buttons, active-high.
REQ-008 sw  input  SW_W  raw number switches.
REQ-009 opCode  output  3  registered event code for the downstream calculator FSM: 000 none, 001 number, 010 enter, 100 add, 101 sub, 110 mul, 111 div.
REQ-010 op_valid  output  1  registered; high exactly in cycles where opCode != 000.
REQ-011 num_out  output  SW_W  registered; the switch value captured on a number event.
REQ-012 busy  output  1  registered; high while the controller is in EMIT or WAIT_REL.

Function
REQ-013 Each of the six buttons and each sw bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each button SHALL have its own debouncer: a stable level register and a counter.
- Counter clears whenever the synchronized sample equals the stable level.
- Otherwise the counter increments; when it reaches DB_COUNT-1, the stable level toggles and the counter clears.
REQ-015 A press event SHALL be a 0->1 transition of a debounced level; 1->0 transitions generate no event.
REQ-016 The controller SHALL be a three-state FSM: IDLE, EMIT, WAIT_REL.
REQ-017 In IDLE, with any press event that cycle, the FSM SHALL latch the winning code and go to EMIT.
- Priority when events coincide: enter > num > add > sub > mul > div.
- Losing events are discarded.
REQ-018 In EMIT, opCode SHALL drive the latched code and op_valid SHALL be 1 for exactly one cycle; the FSM then goes to WAIT_REL.
REQ-019 In WAIT_REL, opCode SHALL be 000 and all new press events SHALL be ignored; the FSM returns to IDLE in the cycle after all six debounced levels are 0.
REQ-020 For a number event, num_out SHALL load the synchronized sw value sampled in the IDLE cycle that detected the event. num_out SHALL become visible in the same cycle opCode=001 and hold until the next number event.
REQ-021 Latency from the first posedge that samples a raw button high (held stable) to opCode valid SHALL be DB_COUNT+3 cycles: 2 synchronizer cycles, DB_COUNT debounce cycles, 1 detect-to-EMIT register.
REQ-022 A raw glitch shorter than DB_COUNT synchronized cycles SHALL produce no event and no change in stable level.
REQ-023 A button held indefinitely SHALL produce exactly one event; a second event requires release of all buttons followed by a new press.
REQ-024 Counters SHALL saturate logic only via REQ-014; no wrap-around event is permitted for any DB_COUNT >= 2.

Reset
REQ-025 When reset=1 at a posedge, all synchronizer flops, stable levels and counters SHALL clear to 0, and the FSM SHALL enter IDLE.
REQ-026 Reset SHALL drive opCode=000, op_valid=0, num_out=0 and busy=0 the following cycle; reset asserted during EMIT SHALL suppress that pulse.
REQ-027 A button already held high across reset deassertion SHALL be debounced afresh and produce one event at DB_COUNT+3 cycles after reset release.

Verification (DB_COUNT=4, SW_W=8)
REQ-028 sw=8'h2A, btn_num held high from cycle 0 -> cycle 7: opCode=001, op_valid=1, num_out=8'h2A, busy=1; cycle 8: opCode=000; no further event while held.
REQ-029 btn_add pulsed high for 3 cycles -> no event, opCode stays 000, busy stays 0.
REQ-030 btn_enter and btn_mul rise in the same cycle and are held -> a single opCode=010 pulse and no 110 ever.
REQ-031 btn_sub pressed, held, released to idle, then pressed again -> exactly two opCode=101 pulses. The second press during WAIT_REL held with btn_div is ignored until all buttons are released.
REQ-032 reset asserted in the EMIT cycle of a btn_div press -> no 111 pulse observed; outputs are 0 the next cycle. With btn_div still held, a 111 pulse occurs 7 cycles after reset release.

Source files
------------

// File: rtl/key_opcode_encoder.sv
// Front end for the calculator: synchronizes and debounces the raw buttons and
// switches, then emits one registered opcode pulse per press with release lockout.
module key_opcode_encoder #(
  parameter int unsigned DB_COUNT = 20'd500000,
  parameter int unsigned SW_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_num,
  input  logic            btn_enter,
  input  logic            btn_add,
  input  logic            btn_sub,
  input  logic            btn_mul,
  input  logic            btn_div,
  input  logic [SW_W-1:0] sw,
  output logic [2:0]      opCode,
  output logic            op_valid,
  output logic [SW_W-1:0] num_out,
  output logic            busy
);

  localparam int unsigned     NB      = 6;
  localparam int unsigned     CNT_W   = (DB_COUNT > 2) ? $clog2(DB_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_NUM   = 3'b001,
    OP_ENTER = 3'b010,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110,
    OP_DIV   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_WAIT_REL
  } state_e;

  // Bit order is the coincident-press priority: bit 0 wins.
  logic [NB-1:0]   w_btn_raw;
  logic [NB-1:0]   r_btn_s1, r_btn_s2;
  logic [SW_W-1:0] r_sw_s1, r_sw_s2;
  logic [NB-1:0]   r_stable, r_stable_d;
  logic [CNT_W-1:0] r_cnt [NB];
  logic [NB-1:0]   w_press;
  op_e             w_press_code;

  state_e          r_state, w_state_nxt;
  op_e             r_code, w_code_nxt;
  logic [SW_W-1:0] r_num_lat, w_num_lat_nxt;
  op_e             w_op_nxt;
  op_e             r_op_code;
  logic            r_op_valid;
  logic [SW_W-1:0] r_num_out;
  logic            r_busy;

  assign w_btn_raw = {btn_div, btn_mul, btn_sub, btn_add, btn_num, btn_enter};

  // NOTE: every flop uses non-blocking assignment so all registers update from
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // NOTE: the counter array is ordinary state, not a RAM, so it is reset
  // element by element like any other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < NB; i++) begin
        if (r_btn_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  always_comb begin
    w_press_code = OP_NONE;
    if      (w_press[0]) w_press_code = OP_ENTER;
    else if (w_press[1]) w_press_code = OP_NUM;
    else if (w_press[2]) w_press_code = OP_ADD;
    else if (w_press[3]) w_press_code = OP_SUB;
    else if (w_press[4]) w_press_code = OP_MUL;
    else if (w_press[5]) w_press_code = OP_DIV;
  end

  // NOTE: defaults come first so no path leaves a variable unassigned, which
  // would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_num_lat_nxt = r_num_lat;
    w_op_nxt      = OP_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_press_code != OP_NONE) begin
          w_state_nxt = S_EMIT;
          w_code_nxt  = w_press_code;
          if (w_press_code == OP_NUM) w_num_lat_nxt = r_sw_s2;
        end
      end
      S_EMIT: begin
        w_op_nxt    = r_code;
        w_state_nxt = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (r_stable == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_code     <= OP_NONE;
      r_num_lat  <= '0;
      r_op_code  <= OP_NONE;
      r_op_valid <= 1'b0;
      r_num_out  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_num_lat  <= w_num_lat_nxt;
      r_op_code  <= w_op_nxt;
      r_op_valid <= (w_op_nxt != OP_NONE);
      r_busy     <= (r_state != S_IDLE);
      if (w_op_nxt == OP_NUM) r_num_out <= r_num_lat;
    end
  end

  assign opCode   = r_op_code;
  assign op_valid = r_op_valid;
  assign num_out  = r_num_out;
  assign busy     = r_busy;

endmodule

// File: tb/tb_key_opcode_encoder.sv
// Directed bench for key_opcode_encoder with DB_COUNT=4: latency, glitch
// rejection, priority, release lockout and reset-during-emit behaviour.
module tb_key_opcode_encoder;

  localparam int DB = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_num, btn_enter, btn_add, btn_sub, btn_mul, btn_div;
  logic [SW-1:0] sw;
  logic [2:0]    opCode;
  logic          op_valid;
  logic [SW-1:0] num_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int n_pulse [8];
  int n_bad_valid = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  key_opcode_encoder #(.DB_COUNT(DB), .SW_W(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_num  (btn_num),
    .btn_enter(btn_enter),
    .btn_add  (btn_add),
    .btn_sub  (btn_sub),
    .btn_mul  (btn_mul),
    .btn_div  (btn_div),
    .sw       (sw),
    .opCode   (opCode),
    .op_valid (op_valid),
    .num_out  (num_out),
    .busy     (busy)
  );

  // Pulse tally per opcode, sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (op_valid === 1'b1) n_pulse[opCode]++;
      if (op_valid !== (opCode != 3'b000)) n_bad_valid++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    btn_num = 0; btn_enter = 0; btn_add = 0; btn_sub = 0; btn_mul = 0; btn_div = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    release_all();
    sw = '0;
    repeat (3) tick();
    mon_en = 1'b1;
    checks++;
    if ({opCode, op_valid, num_out, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: op=%b v=%b num=%h busy=%b, required all 0",
               opCode, op_valid, num_out, busy);
    end
    reset = 1'b0;
    repeat (6) tick();
    checks++;
    if ({opCode, op_valid, busy} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: op=%b v=%b busy=%b, required 0", opCode, op_valid, busy);
    end
  endtask

  task automatic test_number();
    int base = n_pulse[1];
    bit early = 1'b0;
    sw = 8'h2A;
    btn_num = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (op_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL num_latency_early: op_valid seen before cycle 7, required none");
    end
    tick();
    checks++;
    if (opCode !== 3'b001 || op_valid !== 1'b1) begin
      failures++;
      $display("FAIL num_pulse: op=%b v=%b, required 001/1", opCode, op_valid);
    end
    checks++;
    if (num_out !== 8'h2A || busy !== 1'b1) begin
      failures++;
      $display("FAIL num_data: num=%h busy=%b, required 2a/1", num_out, busy);
    end
    tick();
    checks++;
    if (opCode !== 3'b000 || op_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL num_after: op=%b v=%b busy=%b, required 000/0/1", opCode, op_valid, busy);
    end
    sw = 8'h55;
    repeat (20) tick();
    checks++;
    if (n_pulse[1] - base !== 1 || num_out !== 8'h2A) begin
      failures++;
      $display("FAIL num_held: pulses=%0d num=%h, required 1/2a", n_pulse[1] - base, num_out);
    end
    release_all();
    wait_idle();
  endtask

  task automatic test_glitch();
    int base = n_pulse[4];
    bit seen = 1'b0;
    btn_add = 1'b1;
    repeat (3) tick();
    btn_add = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (op_valid !== 1'b0 || opCode !== 3'b000 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || n_pulse[4] !== base) begin
      failures++;
      $display("FAIL glitch: activity=%b add_pulses=%0d, required 0/0", seen, n_pulse[4] - base);
    end
  endtask

  task automatic test_min_press();
    int base = n_pulse[4];
    btn_add = 1'b1;
    repeat (4) tick();
    btn_add = 1'b0;
    repeat (3) tick();
    checks++;
    if (op_valid !== 1'b0) begin
      failures++;
      $display("FAIL min_press_early: op_valid=%b at cycle 6, required 0", op_valid);
    end
    tick();
    checks++;
    if (opCode !== 3'b100 || op_valid !== 1'b1) begin
      failures++;
      $display("FAIL min_press: op=%b v=%b, required 100/1", opCode, op_valid);
    end
    wait_idle();
    checks++;
    if (n_pulse[4] - base !== 1) begin
      failures++;
      $display("FAIL release_no_event: add_pulses=%0d, required 1", n_pulse[4] - base);
    end
  endtask

  task automatic test_coincident();
    int b_ent = n_pulse[2];
    int b_mul = n_pulse[6];
    btn_enter = 1'b1;
    btn_mul   = 1'b1;
    repeat (8) tick();
    checks++;
    if (opCode !== 3'b010 || op_valid !== 1'b1) begin
      failures++;
      $display("FAIL priority_pulse: op=%b v=%b, required 010/1", opCode, op_valid);
    end
    repeat (20) tick();
    release_all();
    wait_idle();
    checks++;
    if (n_pulse[2] - b_ent !== 1 || n_pulse[6] - b_mul !== 0) begin
      failures++;
      $display("FAIL priority_count: enter=%0d mul=%0d, required 1/0",
               n_pulse[2] - b_ent, n_pulse[6] - b_mul);
    end
  endtask

  task automatic test_back_to_back();
    int b_sub = n_pulse[5];
    int b_div = n_pulse[7];
    btn_sub = 1'b1;
    repeat (12) tick();
    btn_div = 1'b1;
    repeat (15) tick();
    checks++;
    if (n_pulse[5] - b_sub !== 1 || n_pulse[7] - b_div !== 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL lockout: sub=%0d div=%0d busy=%b, required 1/0/1",
               n_pulse[5] - b_sub, n_pulse[7] - b_div, busy);
    end
    release_all();
    wait_idle();
    btn_sub = 1'b1;
    repeat (12) tick();
    release_all();
    wait_idle();
    checks++;
    if (n_pulse[5] - b_sub !== 2 || n_pulse[7] - b_div !== 0) begin
      failures++;
      $display("FAIL second_press: sub=%0d div=%0d, required 2/0",
               n_pulse[5] - b_sub, n_pulse[7] - b_div);
    end
  endtask

  task automatic test_reset_in_emit();
    int b_div = n_pulse[7];
    bit early = 1'b0;
    btn_div = 1'b1;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({opCode, op_valid, num_out, busy} !== '0) begin
      failures++;
      $display("FAIL reset_emit: op=%b v=%b num=%h busy=%b, required all 0",
               opCode, op_valid, num_out, busy);
    end
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (op_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early || n_pulse[7] !== b_div) begin
      failures++;
      $display("FAIL reset_suppress: early=%b div=%0d, required 0/0", early, n_pulse[7] - b_div);
    end
    tick();
    checks++;
    if (opCode !== 3'b111 || op_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_div: op=%b v=%b, required 111/1", opCode, op_valid);
    end
    release_all();
    wait_idle();
    checks++;
    if (n_pulse[7] - b_div !== 1) begin
      failures++;
      $display("FAIL div_count: div=%0d, required 1", n_pulse[7] - b_div);
    end
  endtask

  task automatic test_valid_consistency();
    checks++;
    if (n_bad_valid !== 0) begin
      failures++;
      $display("FAIL valid_vs_opcode: mismatched cycles=%0d, required 0", n_bad_valid);
    end
  endtask

  initial begin
    test_reset();
    test_number();
    test_glitch();
    test_min_press();
    test_coincident();
    test_back_to_back();
    test_reset_in_emit();
    test_valid_consistency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
